// File: rtl/window_buffer_pkg.sv
// ------------------------------------------------------------------
// window_buffer_pkg : shared types for the 3x3 window generator
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package window_buffer_pkg;

    localparam int PIX_W = 4;

    // Matches the edge detector's pixelData port: [row][col][bit]
    typedef logic [2:0][2:0][PIX_W-1:0] pixel_window_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/window_buffer_line_buffer.sv
// ------------------------------------------------------------------
// line_buffer : DEPTH-entry delay line built on a circular RAM
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module line_buffer #(
    parameter int DEPTH = 320,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);
    import window_buffer_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] addr;

    // Read and write share one address, so the read returns the value
    // written exactly DEPTH accepted beats earlier.
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            addr <= '0;
        end else if (wr_en) begin
            addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/window_buffer.sv
// ------------------------------------------------------------------
// window_buffer : streaming 3x3 window generator over raster pixels
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module window_buffer #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int PIX_W      = window_buffer_pkg::PIX_W
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        frameStart,
    input  logic [PIX_W-1:0]            pixelIn,
    input  logic                        pixelValid,
    output logic [2:0][2:0][PIX_W-1:0]  pixelWindow,
    output logic                        windowValid,
    output logic                        frameDone
);
    import window_buffer_pkg::*;

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    state_t state, state_next;
    logic [COL_W-1:0] col, col_next, cur_col;
    logic [ROW_W-1:0] row, row_next, cur_row;
    logic             accept;
    logic             win_valid_next;
    logic [PIX_W-1:0] lb1_q, lb2_q;
    logic [2:0][2:0][PIX_W-1:0] window;

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .clk     (clk),
        .nreset  (nreset),
        .wr_en   (accept),
        .wr_data (pixelIn),
        .rd_data (lb1_q)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb2 (
        .clk     (clk),
        .nreset  (nreset),
        .wr_en   (accept),
        .wr_data (lb1_q),
        .rd_data (lb2_q)
    );

    always_comb begin
        // frameStart rebases the counters so a same-cycle pixel lands at (0,0)
        cur_col        = frameStart ? '0 : col;
        cur_row        = frameStart ? '0 : row;
        accept         = pixelValid && (frameStart || state == FILL || state == STREAM);
        state_next     = state;
        col_next       = cur_col;
        row_next       = cur_row;
        win_valid_next = 1'b0;

        if (frameStart) begin
            state_next = FILL;
        end else if (state == DONE) begin
            state_next = IDLE;
        end

        if (accept) begin
            win_valid_next = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
            if (cur_col == COL_LAST) begin
                col_next = '0;
                if (cur_row == ROW_LAST) begin
                    row_next   = '0;
                    state_next = DONE;
                end else begin
                    row_next = cur_row + 1'b1;
                    if (cur_row == ROW_ONE) begin
                        state_next = STREAM;
                    end
                end
            end else begin
                col_next = cur_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            window      <= '0;
            windowValid <= 1'b0;
        end else begin
            state       <= state_next;
            col         <= col_next;
            row         <= row_next;
            windowValid <= win_valid_next;
            if (accept) begin
                window[0][0] <= window[0][1];
                window[0][1] <= window[0][2];
                window[0][2] <= lb2_q;
                window[1][0] <= window[1][1];
                window[1][1] <= window[1][2];
                window[1][2] <= lb1_q;
                window[2][0] <= window[2][1];
                window[2][1] <= window[2][2];
                window[2][2] <= pixelIn;
            end
        end
    end

    assign pixelWindow = window;
    assign frameDone   = (state == DONE);

endmodule

`default_nettype wire
